// File: rtl/ram_port_arb_if.sv
// rtl/ram_port_arb_if.sv - instruction/data request, response and RAM-side signals of the RAM port arbiter
interface ram_port_arb_if #(
   parameter int XLEN     = 32,
   parameter int ADDR_LEN = 14
);
   logic                  i_req;
   logic [ADDR_LEN-3:0]   i_addr;
   logic                  i_gnt;
   logic                  i_rvalid;
   logic [XLEN-1:0]       i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [XLEN/8-1:0]     d_be;
   logic [ADDR_LEN-3:0]   d_addr;
   logic [XLEN-1:0]       d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [XLEN-1:0]       d_rdata;

   logic                  ram_en;
   logic                  ram_we;
   logic [XLEN/8-1:0]     ram_be;
   logic [ADDR_LEN-3:0]   ram_addr;
   logic [XLEN-1:0]       ram_wdata;
   logic [XLEN-1:0]       ram_rdata;

   // master: requesters plus the RAM itself; slave: the arbiter
   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  ram_en, ram_we, ram_be, ram_addr, ram_wdata
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output ram_en, ram_we, ram_be, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_port_arb.sv
// rtl/ram_port_arb.sv - single-port RAM arbiter between instruction fetch and data access, data-priority with starvation cap
module ram_port_arb #(
   parameter int XLEN       = 32,
   parameter int ADDR_LEN   = 14,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rstb,
   ram_port_arb_if.slave bus
);
   localparam int AW = ADDR_LEN - 2;
   localparam int BW = XLEN / 8;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IRD  = 2'd1,
      OWN_DRD  = 2'd2
   } owner_t;

   owner_t          owner;
   logic [3:0]      starve_cnt;
   logic            i_win;
   logic            i_gnt;
   logic            d_gnt;
   logic [AW-1:0]   addr_mux;
   logic [BW-1:0]   be_mux;
   logic [XLEN-1:0] rdata;

   // Grants are gated by rstb so nothing reaches the RAM while reset is held.
   always_comb begin
      i_win    = bus.i_req & (~bus.d_req | (starve_cnt == STARVE_LIM));
      i_gnt    = rstb & i_win;
      d_gnt    = rstb & bus.d_req & ~i_win;
      addr_mux = i_gnt ? bus.i_addr : bus.d_addr;
      be_mux   = (d_gnt & bus.d_we) ? bus.d_be : '0;
      rdata    = bus.ram_rdata;
   end

   assign bus.i_gnt     = i_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.ram_en    = i_gnt | d_gnt;
   assign bus.ram_we    = d_gnt & bus.d_we;
   assign bus.ram_be    = be_mux;
   assign bus.ram_addr  = addr_mux;
   assign bus.ram_wdata = bus.d_wdata;

   assign bus.i_rvalid  = (owner == OWN_IRD);
   assign bus.d_rvalid  = (owner == OWN_DRD);
   assign bus.i_rdata   = rdata;
   assign bus.d_rdata   = rdata;

   // owner records which requester the RAM read data returning next cycle belongs to
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         owner      <= OWN_NONE;
         starve_cnt <= 4'd0;
      end else begin
         if (i_gnt)
            owner <= OWN_IRD;
         else if (d_gnt && !bus.d_we)
            owner <= OWN_DRD;
         else
            owner <= OWN_NONE;

         if (!bus.i_req || i_gnt)
            starve_cnt <= 4'd0;
         else if (d_gnt && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end
endmodule

// File: doc/ram_port_arb.md
RAM_PORT_ARB -- requirements
Module: ram_port_arb

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits.
REQ-002 Parameter ADDR_LEN, default 14, byte address width; word address is ADDR_LEN-2 bits.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive data grants while an instruction request waits; legal range 1..15.
REQ-004 The block SHALL use one clock, clk, and an asynchronous active-low reset, rstb.
REQ-005 Ports SHALL be:
  clk        in   1            clock
  rstb       in   1            async active-low reset
  i_req      in   1            instruction fetch request
  i_addr     in   ADDR_LEN-2   fetch word address
  i_gnt      out  1            fetch accepted this cycle
  i_rvalid   out  1            fetch data valid
  i_rdata    out  XLEN         fetch data
  d_req      in   1            data access request
  d_we       in   1            1 = write, 0 = read
  d_be       in   XLEN/8       write byte enables
  d_addr     in   ADDR_LEN-2   data word address
  d_wdata    in   XLEN         write data
  d_gnt      out  1            data access accepted this cycle
  d_rvalid   out  1            data read valid
  d_rdata    out  XLEN         data read result
  ram_en     out  1            RAM access strobe
  ram_we     out  1            RAM write
  ram_be     out  XLEN/8       RAM byte enables
  ram_addr   out  ADDR_LEN-2   RAM word address
  ram_wdata  out  XLEN         RAM write data
  ram_rdata  in   XLEN         RAM read data, valid one cycle after ram_en with ram_we=0

Function
REQ-006 Grants SHALL be combinational, in the same cycle as the request: at most one of i_gnt and d_gnt is 1 per cycle; ram_en = i_gnt | d_gnt.
REQ-007 A request with only one requester active SHALL be granted in the same cycle.
REQ-008 When both requesters are active, d_req SHALL win unless starve_cnt == STARVE_MAX, in which case i_req SHALL win.
REQ-009 starve_cnt (4 bits) SHALL increment on each cycle in which d_gnt=1 and i_req=1, and SHALL clear on i_gnt=1 or i_req=0; it saturates at STARVE_MAX.
REQ-010 On i_gnt: ram_we=0, ram_be=0, and ram_addr=i_addr. On d_gnt: ram_we=d_we, ram_be=d_be if d_we=1 (else 0), ram_addr=d_addr, and ram_wdata=d_wdata. When idle: ram_we=0, ram_be=0, and ram_addr/ram_wdata hold don't-care.
REQ-011 A response owner register SHALL track the access in flight, with states NONE, IRD and DRD. The next state is IRD after i_gnt, DRD after d_gnt with d_we=0, and NONE otherwise.
REQ-012 i_rvalid SHALL be 1 exactly when owner==IRD, and d_rvalid SHALL be 1 exactly when owner==DRD; each pulses for one cycle, one cycle after the grant.
REQ-013 i_rdata and d_rdata SHALL both be driven from ram_rdata, and are valid only when their respective rvalid is 1.
REQ-014 A write SHALL produce no rvalid pulse; completion of a write is the d_gnt cycle itself.
REQ-015 Back-to-back grants SHALL be supported every cycle, giving full throughput with no bubble between a read response and the next grant.
REQ-016 A requester SHALL hold its request and payload stable until it sees gnt; a deasserted request with no grant is dropped with no side effect.

Reset
REQ-017 While rstb=0: owner=NONE, starve_cnt=0, i_rvalid=0, d_rvalid=0.
REQ-018 Grant outputs and ram_en SHALL be forced to 0 while rstb=0, independent of the request inputs.
REQ-019 After rstb deasserts, arbitration SHALL resume at the first clk edge with the counter at 0.
REQ-020 A read granted in the cycle in which reset asserts SHALL produce no rvalid.

Verification
REQ-021 Fetch only: i_req=1 with i_addr=0x010 for one cycle -> i_gnt=1 and ram_addr=0x010 in the same cycle; i_rvalid=1 in the next cycle with i_rdata equal to the RAM word.
REQ-022 Data write: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x020, d_wdata=0xA5A5_5A5A -> d_gnt=1, ram_we=1 and ram_be=4'b0011 in the same cycle; no d_rvalid follows.
REQ-023 Contention with STARVE_MAX=4: i_req and d_req both held high -> grant pattern D,D,D,D,I repeating; each I grant is followed by an i_rvalid one cycle later.
REQ-024 Interleaved reads: I read, then D read in consecutive cycles -> i_rvalid in cycle 2 and d_rvalid in cycle 3, each carrying its own address's data.
REQ-025 Reset mid-read: assert rstb=0 one cycle after a d_gnt read -> d_rvalid=0 and owner=NONE; after release, a new fetch behaves as in REQ-021.
REQ-026 Request withdrawal: i_req pulsed high while losing to d_req, then dropped -> no i_gnt, no i_rvalid, and starve_cnt returns to 0.
